serial_frame_ring: RTL
======================

// Module: serial_frame_ring
//
// PURPOSE
// - Parametrised recirculating serial frame buffer: WORD_COUNT words of WORD_WIDTH bits in one ring shift register.
// - Loaded LANES bits per clock from a serial pin group; re-emits each word in parallel on dout once per word time.
// - Successor to the fixed 16x8, 1-bit ring: adds lane width, hold/clear modes, word/frame strobes, word index, realignment.
// - Sits between the chip input pins and the byte-wide output pins of the pin-limited top level.
//
// PARAMETERS
// - WORD_WIDTH  8   bits per word; must be a multiple of LANES.
// - WORD_COUNT  16  words in the ring; >= 2.
// - LANES       1   serial bits shifted per clock; 1..WORD_WIDTH.
// - Derived: BEATS = WORD_WIDTH/LANES, RING = WORD_WIDTH*WORD_COUNT, IW = $clog2(WORD_COUNT).
//
// PORTS
// - clk          in   1           single clock, rising edge.
// - reset_n      in   1           asynchronous, active-low reset.
// - mode         in   2           00 RUN (recirculate), 01 WRITE, 10 HOLD, 11 CLEAR.
// - align        in   1           synchronous realign: beat/word counters to 0.
// - din          in   LANES       serial write data; din[LANES-1] is the earliest bit.
// - dout         out  WORD_WIDTH  last completed word, MSB first in shift order.
// - word_valid   out  1           one-cycle pulse: dout updated this cycle.
// - frame_start  out  1           one-cycle pulse with word_valid when word_idx==0.
// - word_idx     out  IW          index of the word currently on dout.
//
// BEHAVIOUR
// - Reset (async, reset_n=0): beat_cnt=0, word_cnt=0, dout=0, word_valid=0, frame_start=0, word_idx=0.
//   Ring contents are NOT reset (area); they are undefined until written.
// - Shift cycle = mode != HOLD. Per shift cycle, ring <= {ring[RING-LANES-1:0], in}, where in is:
//   RUN: ring[RING-1 -: LANES]; WRITE: din; CLEAR: {LANES{1'b0}}.
// - HOLD: ring, beat_cnt, word_cnt, dout and word_idx all freeze; word_valid=frame_start=0.
// - beat_cnt counts 0..BEATS-1 on shift cycles and wraps. Boundary = shift cycle with beat_cnt==BEATS-1.
// - On a boundary: dout <= {ring[WORD_WIDTH-LANES-1:0], in} (i.e. the bits just completing the word; 1-cycle
//   latency from the last din beat); word_idx <= word_cnt; word_valid <= 1; frame_start <= (word_cnt==0);
//   word_cnt <= (word_cnt==WORD_COUNT-1) ? 0 : word_cnt+1.
// - Otherwise, word_valid and frame_start are 0 next cycle; dout and word_idx hold.
// - BEATS==1: every shift cycle is a boundary (word_valid continuously high while shifting).
// - align=1: beat_cnt<=0, word_cnt<=0, no boundary event that cycle (align beats a coinciding boundary).
//   The ring still shifts per mode; dout/word_idx hold.
// - mode changes take effect at the next edge; alignment is preserved across changes (no realign).
// - CLEAR zeroes the full ring after RING/LANES shift cycles; partial CLEAR leaves a mixed frame.
// - Reset asserted mid-word: outputs clear immediately; the next word after release is counted from beat 0.
//
// STRUCTURE
// - Package serial_frame_ring_pkg: mode encodings MODE_RUN/MODE_WRITE/MODE_HOLD/MODE_CLEAR, 2-bit mode typedef.
// - Sub-module frame_ring_counter: beat_cnt/word_cnt with enable, align and boundary/frame_wrap outputs.
// - Top: ring register, input mux, dout/strobe registers.
//
// TESTING (defaults 8/16/1 unless noted)
// - Reset, WRITE 128 bits, words 8'hA0+k MSB first -> word_valid every 8th cycle, dout A0..AF, idx 0..15, frame_start with A0 only.
// - Then RUN 256 cycles -> dout repeats A0..AF twice, frame_start every 128 cycles; ring unchanged.
// - HOLD 5 cycles at beat 3 -> no strobes, dout/idx frozen; next word_valid 5 cycles later than in unstalled RUN.
// - CLEAR 128 cycles then RUN 128 -> sixteen word_valid pulses all with dout=8'h00.
// - align at beat 7 -> no word_valid that cycle; next word_valid 8 cycles later with word_idx=0, frame_start=1.
// - LANES=2, WORD_WIDTH=8: WRITE din=2'b10 x4 -> word_valid after 4 beats, dout=8'hAA; async reset_n pulse mid-word clears outputs with no clk edge.

Source files
------------

// File: rtl/serial_frame_ring_pkg.sv
// Shared definitions for the recirculating serial frame buffer.
// Holds the mode encodings that the top level and the bench both use.
package serial_frame_ring_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_WRITE = 2'b01,
    MODE_HOLD  = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  function automatic logic isShiftMode(input mode_e m);
    return m != MODE_HOLD;
  endfunction

endpackage

// File: rtl/frame_ring_counter.sv
// Beat and word position tracker for the frame ring.
// Flags the shift cycle that completes a word, and the word that starts a new frame.
module frame_ring_counter #(
  parameter int BEATS      = 8,
  parameter int WORD_COUNT = 16,
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int IW = $clog2(WORD_COUNT)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en_i,
  input  logic          align_i,
  output logic [IW-1:0] word_cnt_o,
  output logic          boundary_o,
  output logic          frame_wrap_o
);

  logic [BW-1:0] beat_q, beat_d;
  logic [IW-1:0] word_q, word_d;
  logic          lastBeat;
  logic          lastWord;

  assign lastBeat = (beat_q == BW'(BEATS - 1));
  assign lastWord = (word_q == IW'(WORD_COUNT - 1));

  // Realignment wins over a boundary landing on the same cycle.
  assign boundary_o   = en_i && !align_i && lastBeat;
  assign frame_wrap_o = boundary_o && (word_q == '0);
  assign word_cnt_o   = word_q;

  always_comb begin
    beat_d = beat_q;
    word_d = word_q;
    if (align_i) begin
      beat_d = '0;
      word_d = '0;
    end else if (en_i) begin
      if (lastBeat) begin
        beat_d = '0;
        word_d = lastWord ? '0 : word_q + 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_q <= '0;
      word_q <= '0;
    end else begin
      beat_q <= beat_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/serial_frame_ring.sv
// Recirculating serial frame buffer: a single ring shift register loaded LANES bits
// per clock, re-emitting each completed word in parallel once per word time.
module serial_frame_ring
  import serial_frame_ring_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int WORD_COUNT = 16,
  parameter int LANES      = 1,
  localparam int IW = $clog2(WORD_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  mode_e                 mode,
  input  logic                  align,
  input  logic [LANES-1:0]      din,
  output logic [WORD_WIDTH-1:0] dout,
  output logic                  word_valid,
  output logic                  frame_start,
  output logic [IW-1:0]         word_idx
);

  localparam int BEATS = WORD_WIDTH / LANES;
  localparam int RING  = WORD_WIDTH * WORD_COUNT;

  logic [RING-1:0]       ring_q;
  logic [LANES-1:0]      shiftIn;
  logic [WORD_WIDTH-1:0] completedWord;
  logic                  shiftEn;
  logic                  boundary;
  logic                  frameWrap;
  logic [IW-1:0]         wordCnt;

  logic [WORD_WIDTH-1:0] dout_q;
  logic                  word_valid_q;
  logic                  frame_start_q;
  logic [IW-1:0]         word_idx_q;

  assign shiftEn = isShiftMode(mode);

  always_comb begin
    shiftIn = '0;
    case (mode)
      MODE_RUN:   shiftIn = ring_q[RING-1 -: LANES];
      MODE_WRITE: shiftIn = din;
      default:    shiftIn = '0;
    endcase
  end

  // The word being completed is the tail of the ring plus the bits entering this cycle.
  generate
    if (BEATS == 1) begin : gSingleBeat
      assign completedWord = shiftIn;
    end else begin : gMultiBeat
      assign completedWord = {ring_q[WORD_WIDTH-LANES-1:0], shiftIn};
    end
  endgenerate

  frame_ring_counter #(
    .BEATS      (BEATS),
    .WORD_COUNT (WORD_COUNT)
  ) uCounter (
    .clk          (clk),
    .reset_n      (reset_n),
    .en_i         (shiftEn),
    .align_i      (align),
    .word_cnt_o   (wordCnt),
    .boundary_o   (boundary),
    .frame_wrap_o (frameWrap)
  );

  // Ring storage is deliberately left without reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (shiftEn) begin
      ring_q <= {ring_q[RING-LANES-1:0], shiftIn};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q        <= '0;
      word_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      word_idx_q    <= '0;
    end else begin
      word_valid_q  <= boundary;
      frame_start_q <= frameWrap;
      if (boundary) begin
        dout_q     <= completedWord;
        word_idx_q <= wordCnt;
      end
    end
  end

  assign dout        = dout_q;
  assign word_valid  = word_valid_q;
  assign frame_start = frame_start_q;
  assign word_idx    = word_idx_q;

endmodule
